mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multicycle MIPS control unit that drives the datapath ALU and steers its operands, register file, memory port and PC. It decodes the latched instruction's opcode/funct into the 4-bit ALU operation code and sequences each instruction through a Moore FSM. It consumes the ALU's `zero_flag` and `overflow_flag` for branch resolution and the arithmetic-overflow trap. It sits beside the datapath, with one shared instruction/data memory port using a ready handshake.

## Interface
- `ALU_CTRL_WIDTH`, 4, width of `alu_control` (fixed encoding below)
- `clk` input 1 — single clock, all state updates on rising edge
- `rst_n` input 1 — synchronous, active-low reset
- `opcode` input 6 — instr[31:26] from the instruction register
- `funct` input 6 — instr[5:0] from the instruction register
- `zero_flag` input 1 — ALU result == 0
- `overflow_flag` input 1 — ALU signed overflow
- `mem_ready` input 1 — memory completes the access in this cycle
- `mem_req` output 1 — memory access request
- `mem_write` output 1 — the request is a store
- `iord` output 1 — address source: 0 = PC, 1 = ALUOut
- `ir_write` output 1 — load the instruction register
- `pc_write` output 1 — load the PC
- `pc_src` output 2 — 00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector 0x0000_0180
- `alu_src_a` output 1 — 0 = PC, 1 = [rs]
- `alu_src_b` output 2 — 00 [rt], 01 constant 4, 10 extended imm, 11 sign-extended imm<<2
- `imm_zext` output 1 — zero-extend imm (andi/ori/xori)
- `alu_control` output ALU_CTRL_WIDTH — 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLLV, 1100 SRLV, 1101 SRAV
- `reg_write` output 1 — register file write enable
- `reg_dst` output 1 — 1 = rd, 0 = rt
- `mem_to_reg` output 1 — writeback source is the memory data register
- `exception` output 1 — one-cycle trap pulse
- `exc_cause` output 2 — 01 overflow, 10 illegal instruction; held until the next trap

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, TRAP.
- **FETCH:**
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
  - Otherwise hold in FETCH.
- **DECODE:**
  - Drives `alu_src_a`=0, `alu_src_b`=11, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 0x23 (lw) or 0x2B (sw) → MEMADR
    - 0x04 (beq) or 0x05 (bne) → BRANCH
    - 0x02 (j) → JUMP
    - 0x00 with legal funct, or 0x08–0x0E → EXEC
    - any other opcode or funct → TRAP, cause 10
- **Legal R-type funct:** 0x00, 0x02, 0x03, 0x04, 0x06, 0x07, 0x20–0x27, 0x2A, 0x2B.
- **MEMADR:** `alu_src_a`=1, `alu_src_b`=10, ADD. Then lw → MEMRD, sw → MEMWR.
- **MEMRD:** `mem_req`=1, `iord`=1. Hold until `mem_ready`, then → MEMWB.
- **MEMWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Then → FETCH.
- **MEMWR:** `mem_req`=1, `mem_write`=1, `iord`=1. Hold until `mem_ready`, then → FETCH.
- **EXEC, R-type:** `alu_src_a`=1, `alu_src_b`=00. `alu_control` from funct:
  - add/addu → ADD; sub/subu → SUB; and/or/xor/nor → own code
  - slt → SLT; sltu → SLTU
  - sll/srl/sra → 1000/1001/1010
  - sllv/srlv/srav → 1011/1100/1101
- **EXEC, I-type:** `alu_src_a`=1, `alu_src_b`=10.
  - addi/addiu → ADD; slti → SLT; sltiu → SLTU
  - andi/ori/xori → AND/OR/XOR with `imm_zext`=1
- **EXEC exit:**
  - Trapping ops are add (funct 0x20), sub (funct 0x22) and addi.
  - A trapping op with `overflow_flag`=1 in EXEC → TRAP, cause 01. The register write is suppressed.
  - All other cases → ALUWB.
- **ALUWB:** `reg_write`=1, `mem_to_reg`=0. `reg_dst`=1 for R-type, 0 for I-type. Then → FETCH.
- **BRANCH:**
  - Drives `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01.
  - `pc_write` = (beq & `zero_flag`) | (bne & ~`zero_flag`).
  - Then → FETCH.
- **JUMP:** `pc_write`=1, `pc_src`=10. Then → FETCH.
- **TRAP:** `pc_write`=1, `pc_src`=11, `exception`=1. `exc_cause` is registered on entry. Then → FETCH.
- **Default outputs:** any output not listed for a state is 0. `alu_control` defaults to ADD.

## Timing
- **Reset:**
  - `rst_n` sampled low → state = FETCH, `exc_cause` = 00.
  - While `rst_n` is low, every output is forced to 0, including `mem_req`. Outputs gate combinationally on `rst_n`.
  - Reset mid-instruction abandons it; no write enable is asserted in that cycle.
- **Output timing:** outputs are Moore, decoded from the current state. The exceptions are `ir_write`, `pc_write` and state advance in FETCH/MEMRD/MEMWR, which qualify on `mem_ready`, and `pc_write` in BRANCH, which qualifies on `zero_flag`.
- **Memory handshake:**
  - `mem_req` stays high, with address/write selects stable, every cycle until `mem_ready`=1.
  - The transfer occurs in the cycle where both are 1.
  - `mem_ready` while `mem_req`=0 is ignored.
- **Latency with zero wait states:** R/I ALU op 4 cycles, lw 5, sw 4, beq/bne 3, j 3, trap from DECODE 3, overflow trap 4.
- **Wait states:** each wait cycle on `mem_ready` adds one cycle.

## Test plan
- Reset with `rst_n`=0 for 3 cycles, `mem_ready`=1 → all outputs 0. First cycle after release: `mem_req`=1, `iord`=0, `alu_control`=0010.
- add (op 0, funct 0x20), `overflow_flag`=0, no waits → ALUWB in cycle 4 with `reg_write`=1, `reg_dst`=1. The EXEC cycle shows `alu_control`=0010.
- lw with `mem_ready` low for 2 cycles in both FETCH and MEMRD → 9 cycles total. `mem_req` held steady; `mem_to_reg`=1 in MEMWB.
- beq with `zero_flag`=1 → `pc_write`=1, `pc_src`=01. bne with `zero_flag`=1 → `pc_write`=0. Each takes 3 cycles.
- addi with `overflow_flag`=1 in EXEC → no `reg_write`. TRAP follows with `exception`=1, `pc_src`=11, `exc_cause`=01, then FETCH.
- op 0, funct 0x3F → TRAP after DECODE with `exc_cause`=10. sllv (funct 0x04) → `alu_control`=1011. ori → `imm_zext`=1 with `alu_control`=0001.

Source files
------------

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Purpose  : Multicycle MIPS control unit. Moore FSM that sequences each
//            instruction through fetch, decode, execute, memory and
//            writeback. Decodes opcode/funct into the ALU operation code.
//            Raises a trap on an illegal instruction or on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      zero_flag,
  input  logic                      overflow_flag,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      mem_write,
  output logic                      iord,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic [1:0]                pc_src,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic                      imm_zext,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control,
  output logic                      reg_write,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      exception,
  output logic [1:0]                exc_cause
);

  // ALU operation encodings
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_AND  = 4'b0000;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_OR   = 4'b0001;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_XOR  = 4'b0011;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_NOR  = 4'b0100;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SLTU = 4'b0101;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SLT  = 4'b0111;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SLL  = 4'b1000;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SRL  = 4'b1001;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SRA  = 4'b1010;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SLLV = 4'b1011;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SRLV = 4'b1100;
  localparam logic [ALU_CTRL_WIDTH-1:0] c_ALU_SRAV = 4'b1101;

  // Opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // Trap causes
  localparam logic [1:0] c_CAUSE_OVF = 2'b01;
  localparam logic [1:0] c_CAUSE_ILL = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_exc_cause;
  logic [1:0] w_cause;
  logic       w_is_rtype;
  logic       w_is_itype_alu;
  logic       w_trapping_op;

  function automatic logic f_rtype_legal(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_WIDTH-1:0] f_rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h00:        return c_ALU_SLL;
      6'h02:        return c_ALU_SRL;
      6'h03:        return c_ALU_SRA;
      6'h04:        return c_ALU_SLLV;
      6'h06:        return c_ALU_SRLV;
      6'h07:        return c_ALU_SRAV;
      6'h22, 6'h23: return c_ALU_SUB;
      6'h24:        return c_ALU_AND;
      6'h25:        return c_ALU_OR;
      6'h26:        return c_ALU_XOR;
      6'h27:        return c_ALU_NOR;
      6'h2A:        return c_ALU_SLT;
      6'h2B:        return c_ALU_SLTU;
      default:      return c_ALU_ADD;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_WIDTH-1:0] f_itype_alu(input logic [5:0] op);
    case (op)
      6'h0A:   return c_ALU_SLT;
      6'h0B:   return c_ALU_SLTU;
      6'h0C:   return c_ALU_AND;
      6'h0D:   return c_ALU_OR;
      6'h0E:   return c_ALU_XOR;
      default: return c_ALU_ADD;
    endcase
  endfunction

  assign w_is_rtype     = (opcode == c_OP_RTYPE);
  assign w_is_itype_alu = (opcode >= c_OP_ADDI) && (opcode <= c_OP_XORI);
  // add, sub and addi are the only ops that trap on signed overflow
  assign w_trapping_op  = (w_is_rtype && (funct == 6'h20 || funct == 6'h22)) ||
                          (opcode == c_OP_ADDI);

  // State register and trap cause, latched as the FSM enters TRAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_exc_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) begin
        r_exc_cause <= w_cause;
      end
    end
  end

  // Next-state and Moore output decode; everything forced low in reset
  always_comb begin
    w_next      = r_state;
    w_cause     = 2'b00;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    imm_zext    = 1'b0;
    alu_control = c_ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    exception   = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b = 2'b11;
        if (opcode == c_OP_LW || opcode == c_OP_SW) begin
          w_next = S_MEMADR;
        end else if (opcode == c_OP_BEQ || opcode == c_OP_BNE) begin
          w_next = S_BRANCH;
        end else if (opcode == c_OP_J) begin
          w_next = S_JUMP;
        end else if ((w_is_rtype && f_rtype_legal(funct)) || w_is_itype_alu) begin
          w_next = S_EXEC;
        end else begin
          w_next  = S_TRAP;
          w_cause = c_CAUSE_ILL;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (w_is_rtype) begin
          alu_src_b   = 2'b00;
          alu_control = f_rtype_alu(funct);
        end else begin
          alu_src_b   = 2'b10;
          alu_control = f_itype_alu(opcode);
          imm_zext    = (opcode >= 6'h0C) && (opcode <= c_OP_XORI);
        end
        if (w_trapping_op && overflow_flag) begin
          w_next  = S_TRAP;
          w_cause = c_CAUSE_OVF;
        end else begin
          w_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = w_is_rtype;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b00;
        alu_control = c_ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = ((opcode == c_OP_BEQ) && zero_flag) ||
                      ((opcode == c_OP_BNE) && !zero_flag);
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        pc_write  = 1'b1;
        pc_src    = 2'b11;
        exception = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase

    if (!rst_n) begin
      w_next      = S_FETCH;
      w_cause     = 2'b00;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      imm_zext    = 1'b0;
      alu_control = '0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      exception   = 1'b0;
    end
  end

  assign exc_cause = rst_n ? r_exc_cause : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_control
// Purpose  : Self-checking bench for mips_mc_control. Each driven cycle pushes
//            its expected output vector to a scoreboard queue; a monitor on
//            the falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;

  localparam logic [3:0] c_ADD  = 4'b0010;
  localparam logic [3:0] c_SUB  = 4'b0110;
  localparam logic [3:0] c_OR   = 4'b0001;
  localparam logic [3:0] c_SLLV = 4'b1011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       overflow_flag;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [3:0] alu_control;
  logic       reg_write, reg_dst, mem_to_reg, exception;
  logic [1:0] exc_cause;

  always #5 clk = ~clk;

  mips_mc_control #(.ALU_CTRL_WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero_flag     (zero_flag),
    .overflow_flag (overflow_flag),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_zext      (imm_zext),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .exception     (exception),
    .exc_cause     (exc_cause)
  );

  // Field order: mreq mwr iord irw pcw pcsrc[2] asa asb[2] zext alu[4] rw rdst m2r exc cause[2]
  logic [20:0] w_obs;
  assign w_obs = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, imm_zext, alu_control, reg_write, reg_dst, mem_to_reg,
                  exception, exc_cause};

  typedef struct {
    string       tag;
    logic [20:0] exp;
  } sb_t;

  sb_t        r_sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_cause;

  task automatic check_eq(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %06h expected %06h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [20:0] ev(input logic mreq, mwr, io, irw, pcw,
                                     input logic [1:0] pcs, input logic asa,
                                     input logic [1:0] asb, input logic zx,
                                     input logic [3:0] alu, input logic rw, rd, m2r, exc,
                                     input logic [1:0] cause);
    return {mreq, mwr, io, irw, pcw, pcs, asa, asb, zx, alu, rw, rd, m2r, exc, cause};
  endfunction

  function automatic logic [20:0] f_fetch(input logic rdy);
    return ev(1, 0, 0, rdy, rdy, 2'b00, 0, 2'b01, 0, c_ADD, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_decode();
    return ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, c_ADD, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_memadr();
    return ev(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, c_ADD, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_memrd();
    return ev(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, c_ADD, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_memwb();
    return ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, c_ADD, 1, 0, 1, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_memwr();
    return ev(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, c_ADD, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_exec_r(input logic [3:0] alu);
    return ev(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, alu, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_exec_i(input logic [3:0] alu, input logic zx);
    return ev(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, zx, alu, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_aluwb(input logic rd);
    return ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, c_ADD, 1, rd, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_branch(input logic pcw);
    return ev(0, 0, 0, 0, pcw, 2'b01, 1, 2'b00, 0, c_SUB, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_jump();
    return ev(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, c_ADD, 0, 0, 0, 0, exp_cause);
  endfunction
  function automatic logic [20:0] f_trap();
    return ev(0, 0, 0, 0, 1, 2'b11, 0, 2'b00, 0, c_ADD, 0, 0, 0, 1, exp_cause);
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation
  task automatic step(input string tag, input logic rn, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic ov,
                      input logic rdy, input logic [20:0] exp);
    @(posedge clk);
    #1;
    rst_n         = rn;
    opcode        = op;
    funct         = fn;
    zero_flag     = z;
    overflow_flag = ov;
    mem_ready     = rdy;
    r_sb.push_back('{tag, exp});
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  always @(negedge clk) begin
    if (r_sb.size() > 0) begin
      sb_t e;
      e = r_sb.pop_front();
      check_eq(e.tag, w_obs, e.exp);
    end
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0;
    zero_flag = 1'b0; overflow_flag = 1'b0; mem_ready = 1'b1;
    exp_cause = 2'b00;

    // Reset: all outputs forced low even with mem_ready high
    for (int i = 0; i < 3; i++) step("reset", 0, 6'h00, 6'h00, 0, 0, 1, '0);

    // add, no overflow: 4 cycles
    step("add_fetch",  1, 6'h00, 6'h20, 0, 0, 1, f_fetch(1));
    step("add_decode", 1, 6'h00, 6'h20, 0, 0, 1, f_decode());
    step("add_exec",   1, 6'h00, 6'h20, 0, 0, 1, f_exec_r(c_ADD));
    step("add_aluwb",  1, 6'h00, 6'h20, 0, 0, 1, f_aluwb(1));

    // lw with two wait states in FETCH and in MEMRD: 9 cycles
    step("lw_fetch_w0", 1, 6'h23, 6'h00, 0, 0, 0, f_fetch(0));
    step("lw_fetch_w1", 1, 6'h23, 6'h00, 0, 0, 0, f_fetch(0));
    step("lw_fetch",    1, 6'h23, 6'h00, 0, 0, 1, f_fetch(1));
    step("lw_decode",   1, 6'h23, 6'h00, 0, 0, 1, f_decode());
    step("lw_memadr",   1, 6'h23, 6'h00, 0, 0, 1, f_memadr());
    step("lw_memrd_w0", 1, 6'h23, 6'h00, 0, 0, 0, f_memrd());
    step("lw_memrd_w1", 1, 6'h23, 6'h00, 0, 0, 0, f_memrd());
    step("lw_memrd",    1, 6'h23, 6'h00, 0, 0, 1, f_memrd());
    step("lw_memwb",    1, 6'h23, 6'h00, 0, 0, 1, f_memwb());

    // sw: 4 cycles
    step("sw_fetch",  1, 6'h2B, 6'h00, 0, 0, 1, f_fetch(1));
    step("sw_decode", 1, 6'h2B, 6'h00, 0, 0, 1, f_decode());
    step("sw_memadr", 1, 6'h2B, 6'h00, 0, 0, 1, f_memadr());
    step("sw_memwr",  1, 6'h2B, 6'h00, 0, 0, 1, f_memwr());

    // beq taken, bne not taken with zero_flag=1
    step("beq_fetch",  1, 6'h04, 6'h00, 1, 0, 1, f_fetch(1));
    step("beq_decode", 1, 6'h04, 6'h00, 1, 0, 1, f_decode());
    step("beq_branch", 1, 6'h04, 6'h00, 1, 0, 1, f_branch(1));
    step("bne_fetch",  1, 6'h05, 6'h00, 1, 0, 1, f_fetch(1));
    step("bne_decode", 1, 6'h05, 6'h00, 1, 0, 1, f_decode());
    step("bne_branch", 1, 6'h05, 6'h00, 1, 0, 1, f_branch(0));

    // j
    step("j_fetch",  1, 6'h02, 6'h00, 0, 0, 1, f_fetch(1));
    step("j_decode", 1, 6'h02, 6'h00, 0, 0, 1, f_decode());
    step("j_jump",   1, 6'h02, 6'h00, 0, 0, 1, f_jump());

    // addi overflow: write suppressed, trap with cause 01
    step("addi_fetch",  1, 6'h08, 6'h00, 0, 0, 1, f_fetch(1));
    step("addi_decode", 1, 6'h08, 6'h00, 0, 0, 1, f_decode());
    step("addi_exec",   1, 6'h08, 6'h00, 0, 1, 1, f_exec_i(c_ADD, 0));
    exp_cause = 2'b01;
    step("ovf_trap",    1, 6'h08, 6'h00, 0, 0, 1, f_trap());

    // Illegal funct 0x3F: cause held at 01 until the new trap sets 10
    step("ill_fetch",  1, 6'h00, 6'h3F, 0, 0, 1, f_fetch(1));
    step("ill_decode", 1, 6'h00, 6'h3F, 0, 0, 1, f_decode());
    exp_cause = 2'b10;
    step("ill_trap",   1, 6'h00, 6'h3F, 0, 0, 1, f_trap());

    // sllv
    step("sllv_fetch",  1, 6'h00, 6'h04, 0, 0, 1, f_fetch(1));
    step("sllv_decode", 1, 6'h00, 6'h04, 0, 0, 1, f_decode());
    step("sllv_exec",   1, 6'h00, 6'h04, 0, 0, 1, f_exec_r(c_SLLV));
    step("sllv_aluwb",  1, 6'h00, 6'h04, 0, 0, 1, f_aluwb(1));

    // ori: zero-extended immediate, I-type writeback to rt
    step("ori_fetch",  1, 6'h0D, 6'h00, 0, 0, 1, f_fetch(1));
    step("ori_decode", 1, 6'h0D, 6'h00, 0, 0, 1, f_decode());
    step("ori_exec",   1, 6'h0D, 6'h00, 0, 0, 1, f_exec_i(c_OR, 1));
    step("ori_aluwb",  1, 6'h0D, 6'h00, 0, 0, 1, f_aluwb(0));

    // Reset mid-instruction abandons it and clears the cause
    step("mid_fetch", 1, 6'h00, 6'h20, 0, 0, 1, f_fetch(1));
    step("mid_reset", 0, 6'h00, 6'h20, 0, 0, 1, '0);
    exp_cause = 2'b00;
    step("post_fetch", 1, 6'h00, 6'h20, 0, 0, 1, f_fetch(1));

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
